cmp_seq_ctrl: RTL and testbench
===============================

# cmp_seq_ctrl

Sequencing controller that reuses a single 2-bit magnitude-comparator slice to compare two WIDTH-bit operands, MSB slice first, one slice per clock. Accepts a start request, walks the operand slices with an internal index counter, latches the first unequal slice decision, and reports GT/EQ/LT with a one-cycle done pulse. It sits between operand registers and consumers needing an N-bit compare without an N-bit combinational comparator.

## Interface
- WIDTH, 8, operand width in bits; even, ≥2; SLICES = WIDTH/2
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- inA  in  WIDTH  operand A; captured on accepted start
- inB  in  WIDTH  operand B; captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- outGT  out  1  registered result A>B
- outEQ  out  1  registered result A=B
- outLT  out  1  registered result A<B

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture inA/inB, idx=SLICES-1, clear outGT/outEQ/outLT to 0 and the decided flag to 0, go to RUN. start=0 → stay.
- RUN: compare slice idx, which is bits [2*idx+1:2*idx] of the captured operands.
  - Slice unequal and not yet decided → latch slice GT/LT into the decision, set decided.
  - Terminate when the decision is made (macro on), or when idx==0.
  - On termination, load outGT/outLT from the decision, or set outEQ=1 if nothing was decided, then go to DONE.
  - Otherwise decrement idx.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Results are one-hot after done. They hold until the next accepted start.
- start in RUN/DONE is ignored. It is not queued.
- Operand input changes after capture have no effect.
- idx width: clog2(SLICES), minimum 1. No wrap: idx never decrements below 0.
- Once decided, the decision is sticky. Lower slices never override it.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, outGT=outEQ=outLT=0, idx=0, decided=0. Deassertion is synchronous to clk.
- Start sampled at edge 0 → RUN from cycle 1. Slice k (k=1 is MSB) is compared in cycle k.
- The deciding or last slice is in cycle k. done=1 and the results are visible in cycle k+1. busy=0 and IDLE in cycle k+2.
- Latency start→done: k+1 cycles. k is the first differing slice (macro on), or SLICES (macro off, or operands equal).
- Minimum start-to-start interval: k+2 cycles.
- The comparator slice is combinational. No pipeline inside RUN.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN terminates in the cycle of the first unequal slice. Latency is data-dependent.
- CMP_EARLY_EXIT_EN undefined: RUN always runs SLICES cycles. The decision is latched but the walk continues, giving constant-time latency of SLICES+1.
- Results are identical in both builds. Only done timing differs.

## Structure
- Package cmp_pkg:
  - state typedef (IDLE/RUN/DONE)
  - slice result typedef/encoding (GT/EQ/LT)
  - SLICE_W=2 constant
- Sub-module cmp2_slice: purely combinational 2-bit comparator, inputs a[1:0] and b[1:0], outputs gt/eq/lt. Instantiated once and fed by idx-muxed operand slices.
- The top holds the FSM, idx counter, operand registers, decision/result registers.

## Test plan
- Reset then idle, WIDTH=8 → all outputs 0. start=1, A=8'hA5, B=8'hA5 → busy from cycle 1, done=1 in cycle 5, outEQ=1, outGT=outLT=0.
- A=8'h80, B=8'h7F → outGT=1. done in cycle 2 with macro on, cycle 5 with macro off.
- A=8'h34, B=8'h35 → outLT=1, done in cycle 5 in both builds. Results hold until the next start.
- Pulse start in cycles 1–4 with different operands during an A=8'h00/B=8'hC0 compare → ignored. outLT=1 reflects the original operands. Change inA/inB mid-RUN → no effect.
- Assert reset_n=0 in cycle 2 of a compare → all outputs 0 immediately. After release, a new start A=8'hFF, B=8'h00 yields outGT=1.
- Back-to-back: start held high continuously → new compare accepted each time IDLE is reached, i.e. every k+2 cycles. done pulses exactly one cycle each.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, slice
// result encoding and the slice width.
package cmp_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SL_EQ = 2'b00,
    SL_GT = 2'b01,
    SL_LT = 2'b10
  } slice_res_t;

  // Illegal flag combinations are folded to EQ so they can never decide.
  function automatic slice_res_t encode_slice(input logic gt, input logic eq, input logic lt);
    slice_res_t res;
    res = SL_EQ;
    unique case ({gt, eq, lt})
      3'b100:  res = SL_GT;
      3'b001:  res = SL_LT;
      default: res = SL_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational 2-bit magnitude comparator slice.
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequential WIDTH-bit comparator reusing one 2-bit slice, MSB slice first.
// Optional macro CMP_EARLY_EXIT_EN ends the walk at the first unequal slice.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic             outGT,
  output logic             outEQ,
  output logic             outLT
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               decided;
  logic               dec_gt;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic               s_gt;
  logic               s_eq;
  logic               s_lt;
  slice_res_t         s_res;
  logic               new_dec;
  logic               next_decided;
  logic               next_gt;
  logic               finish;

  assign slice_a = op_a[idx*SLICE_W +: SLICE_W];
  assign slice_b = op_b[idx*SLICE_W +: SLICE_W];

  cmp2_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  assign s_res = encode_slice(s_gt, s_eq, s_lt);

  // A decision, once taken, is sticky: lower slices only matter while undecided.
  always_comb begin
    new_dec      = (s_res != SL_EQ) && !decided;
    next_decided = decided || (s_res != SL_EQ);
    next_gt      = decided ? dec_gt : (s_res == SL_GT);
`ifdef CMP_EARLY_EXIT_EN
    finish       = new_dec || (idx == '0);
`else
    finish       = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      outGT   <= 1'b0;
      outEQ   <= 1'b0;
      outLT   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a    <= inA;
            op_b    <= inB;
            idx     <= IDX_W'(SLICES - 1);
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            outGT   <= 1'b0;
            outEQ   <= 1'b0;
            outLT   <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (new_dec) begin
            decided <= 1'b1;
            dec_gt  <= (s_res == SL_GT);
          end
          if (finish) begin
            if (next_decided) begin
              outGT <= next_gt;
              outLT <= !next_gt;
            end else begin
              outEQ <= 1'b1;
            end
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl; expected results are queued on start and
// popped when done pulses.
module tb_cmp_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int SLICES = WIDTH / 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] inA = '0;
  logic [WIDTH-1:0] inB = '0;
  logic             busy, done, outGT, outEQ, outLT;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   lat;
  } exp_t;

  exp_t sb[$];

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .busy    (busy),
    .done    (done),
    .outGT   (outGT),
    .outEQ   (outEQ),
    .outLT   (outLT)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   k;
    e.gt = (a > b);
    e.eq = (a == b);
    e.lt = (a < b);
    k = SLICES;
`ifdef CMP_EARLY_EXIT_EN
    for (int s = SLICES; s >= 1; s--)
      if (a[WIDTH-2*s +: 2] != b[WIDTH-2*s +: 2]) k = s;
`endif
    e.lat = k + 1;
    return e;
  endfunction

  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
    exp_t e;
    int   cyc;
    bit   got;
    sb.push_back(model(a, b));
    @(negedge clk);
    inA = a; inB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; cyc = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy cycle1 got=%b exp=1", name, busy); end
      end
      if (done === 1'b1) begin got = 1; cyc = c; end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s_timeout no done within 20 cycles", name);
    end else begin
      if (cyc != e.lat) begin n_bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc, e.lat); end
      n_cmp++;
      if ({outGT, outEQ, outLT} !== {e.gt, e.eq, e.lt}) begin
        n_bad++; $display("FAIL %s_result gt/eq/lt got=%b%b%b exp=%b%b%b", name, outGT, outEQ, outLT, e.gt, e.eq, e.lt);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL %s_after busy/done got=%b%b exp=00", name, busy, done); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, outGT, outEQ, outLT} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b exp=00000", {busy, done, outGT, outEQ, outLT});
    end
  endtask

  task automatic test_eq();
    run_cmp(8'hA5, 8'hA5, "eq");
  endtask

  task automatic test_gt();
    run_cmp(8'h80, 8'h7F, "gt");
  endtask

  task automatic test_lt_hold();
    run_cmp(8'h34, 8'h35, "lt");
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({outGT, outEQ, outLT} !== 3'b001) begin
      n_bad++; $display("FAIL lt_hold got=%b%b%b exp=001", outGT, outEQ, outLT);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   cyc;
    bit   got;
    sb.push_back(model(8'h00, 8'hC0));
    @(negedge clk);
    inA = 8'h00; inB = 8'hC0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; cyc = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1; cyc = c;
        start = 1'b1;
      end else begin
        start = c[0];
        inA = 8'(c * 37);
        inB = ~inA;
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL ignore_timeout no done within 20 cycles");
    end else begin
      if (cyc != e.lat) begin n_bad++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, e.lat); end
      n_cmp++;
      if ({outGT, outEQ, outLT} !== {e.gt, e.eq, e.lt}) begin
        n_bad++; $display("FAIL ignore_result got=%b%b%b exp=%b%b%b", outGT, outEQ, outLT, e.gt, e.eq, e.lt);
      end
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle busy got=%b exp=0", busy); end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_not_queued busy got=%b exp=0", busy); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    inA = 8'h55; inB = 8'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, outGT, outEQ, outLT} !== 5'b0) begin
      n_bad++; $display("FAIL reset_mid_outputs got=%b exp=00000", {busy, done, outGT, outEQ, outLT});
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_cmp(8'hFF, 8'h00, "post_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e, p;
    int   ndone, next_at;
    bit   prev_done;
    e = model(8'h34, 8'h35);
    repeat (3) sb.push_back(e);
    @(negedge clk);
    inA = 8'h34; inB = 8'h35; start = 1'b1;
    ndone = 0; next_at = e.lat; prev_done = 0;
    for (int c = 1; c <= 60 && ndone < 3; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        p = sb.pop_front();
        n_cmp++;
        if (c != next_at || prev_done) begin
          n_bad++; $display("FAIL b2b_timing done at cycle %0d exp=%0d", c, next_at);
        end
        n_cmp++;
        if ({outGT, outEQ, outLT} !== {p.gt, p.eq, p.lt}) begin
          n_bad++; $display("FAIL b2b_result got=%b%b%b exp=%b%b%b", outGT, outEQ, outLT, p.gt, p.eq, p.lt);
        end
        ndone++;
        next_at = c + e.lat + 1;
        if (ndone == 3) start = 1'b0;
      end
      prev_done = (done === 1'b1);
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 3) begin
      n_bad++; $display("FAIL b2b_count got=%0d exp=3", ndone);
      sb.delete();
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_end busy/done got=%b%b exp=00", busy, done); end
  endtask

  initial begin
    test_reset();
    test_eq();
    test_gt();
    test_lt_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
